segre_hazard_tracker: RTL and testbench
=======================================

# segre_hazard_tracker

Producer-side companion of the ID-stage bypass controller. It records the destination register of every instruction in EX, MEM and WB in a three-entry shift pipeline. From these entries it generates the per-stage dependency flags that the bypass controller turns into forwarding mux selects. It also raises the load-use stall to ID, and sits beside the decode stage.

## Interface
- REG_SIZE, 5 (from segre_pkg): register identifier width.
- clk_i  input  1  clock; all state updates on the rising edge.
- rsn_i  input  1  asynchronous active-low reset.
- valid_id_i  input  1  ID holds a valid instruction.
- wr_rd_id_i  input  1  ID instruction writes its destination register.
- is_load_id_i  input  1  ID instruction is a load; its result is forwardable only from WB.
- dst_reg_identifier_id_i  input  REG_SIZE  ID destination register.
- src_a_identifier_id_i, src_b_identifier_id_i  input  REG_SIZE  ID source registers.
- rd_src_a_id_i, rd_src_b_id_i  input  1  ID actually reads src a / src b.
- hold_i  input  1  global pipeline freeze (e.g. memory miss); no entry moves.
- flush_i  input  1  kill the ID instruction; a bubble enters EX.
- valid_ex_o, valid_mem_o, valid_wb_o  output  1  stage holds a register-writing instruction.
- dst_reg_identifier_ex_o, dst_reg_identifier_mem_o, dst_reg_identifier_wb_o  output  REG_SIZE  stage destination register.
- depEX_src_a_o, depEX_src_b_o, depMEM_src_a_o, depMEM_src_b_o, depWB_src_a_o, depWB_src_b_o  output  1  one-hot-per-source dependency flags.
- stall_id_o  output  1  load-use hazard; ID must hold its instruction.
- busy_o  output  1  any of the three entries is valid.

## Operation
- Entry fields: valid, dst reg, is_load. An entry is valid only if its instruction was valid, writes rd, and rd != 0.
- Advance when hold_i=0:
  - WB <= MEM; MEM <= EX.
  - EX <= the ID instruction when issue = valid_id_i & ~stall_id_o & ~flush_i.
  - Otherwise EX <= bubble (valid=0).
- When hold_i=1:
  - All entries keep their values.
  - flush_i is ignored; upstream keeps flush_i asserted until hold_i drops.
- Match for source s in stage X: rd_src_s_id_i & valid_X & (dst_X == src_s) & (src_s != 0).
- Dependency priority is youngest first: EX > MEM > WB.
  - depEX_s = match_EX.
  - depMEM_s = match_MEM & ~match_EX.
  - depWB_s = match_WB & ~match_EX & ~match_MEM.
  - At most one dep flag per source is high.
- stall_id_o is high when, for either source, the selected producer is a load in EX or MEM.
  - While stall_id_o is high, all dep flags for that source are still reported.
  - The consumer ignores dep flags during a stall.
- stall_id_o is gated by valid_id_i. It is also gated by flush_i: a flushed instruction never stalls.
- busy_o = valid_ex | valid_mem | valid_wb.

## Timing
- Reset (rsn_i=0, asynchronous): all entry valid bits = 0, dst = 0, is_load = 0.
  - Consequently every output is 0 during reset and in the first cycle after release.
- Dep flags and stall_id_o are combinational from the registered entries and the current ID inputs. There is no added latency; they are valid in the same cycle as the ID instruction.
- An instruction issued in cycle t is in EX at t+1, MEM at t+2 and WB at t+3, given no hold.
- Load-use with the consumer directly behind the load:
  - Stall for 2 cycles.
  - The consumer then sees depWB, 3 cycles after the load issued.
- A non-load producer in EX forwards with no stall.
- Same register produced in EX and MEM: only depEX is set, because the younger producer wins.
- A source of x0 or a non-read source never matches. An rd = x0 producer never creates an entry.
- Reset mid-operation clears all entries immediately. No state survives reset.
- stall_id_o and flush_i in the same cycle: flush wins, and a bubble enters EX.
- hold_i and stall_id_o together: stall_id_o is still reported; the entries stay frozen.

## Test plan
- Reset, then issue ADD x5 at t0 and a reader of x5 on src a at t1.
  - Required: depEX_src_a_o=1 at t1, stall_id_o=0.
  - Required: a reader at t2 gets depMEM, a reader at t3 gets depWB, a reader at t4 gets no dep.
- LW x7, then a reader of x7 on src b.
  - Required: stall_id_o=1 for exactly 2 cycles.
  - Required: on the third cycle depWB_src_b_o=1 and stall_id_o=0; exactly 2 bubbles are visible in EX.
- ADD x3 at t0, SUB x3 at t1, a reader of x3 on both sources at t2.
  - Required: depEX_src_a_o=depEX_src_b_o=1 and depMEM_*=0.
- Write to x0, then a reader of x0; also a reader with rd_src_a_id_i=0 that matches x9 in EX.
  - Required: all dep flags 0 and stall_id_o=0 in both cases.
- hold_i=1 for 3 cycles with entries in EX, MEM and WB.
  - Required: valid_* and dst_* unchanged throughout; they advance one stage on the first cycle after hold drops.
- Assert rsn_i low asynchronously mid-cycle with all entries valid.
  - Required: busy_o and all outputs drop to 0 immediately.
  - Stall case: assert flush_i together with a load-use stall. Required: stall_id_o=0 and EX becomes a bubble.

Source files
------------

// File: rtl/segre_hazard_tracker.sv
// Producer-side hazard tracker: shifts ID destination registers through EX/MEM/WB entries and
// derives per-source dependency flags and the load-use stall for the decode stage.
module segre_hazard_tracker #(
  parameter int unsigned REG_SIZE = 5
) (
  input  logic                clk_i,
  input  logic                rsn_i,
  input  logic                valid_id_i,
  input  logic                wr_rd_id_i,
  input  logic                is_load_id_i,
  input  logic [REG_SIZE-1:0] dst_reg_identifier_id_i,
  input  logic [REG_SIZE-1:0] src_a_identifier_id_i,
  input  logic [REG_SIZE-1:0] src_b_identifier_id_i,
  input  logic                rd_src_a_id_i,
  input  logic                rd_src_b_id_i,
  input  logic                hold_i,
  input  logic                flush_i,
  output logic                valid_ex_o,
  output logic                valid_mem_o,
  output logic                valid_wb_o,
  output logic [REG_SIZE-1:0] dst_reg_identifier_ex_o,
  output logic [REG_SIZE-1:0] dst_reg_identifier_mem_o,
  output logic [REG_SIZE-1:0] dst_reg_identifier_wb_o,
  output logic                depEX_src_a_o,
  output logic                depEX_src_b_o,
  output logic                depMEM_src_a_o,
  output logic                depMEM_src_b_o,
  output logic                depWB_src_a_o,
  output logic                depWB_src_b_o,
  output logic                stall_id_o,
  output logic                busy_o
);

  logic                r_valid_ex, r_valid_mem, r_valid_wb;
  logic [REG_SIZE-1:0] r_dst_ex, r_dst_mem, r_dst_wb;
  logic                r_load_ex, r_load_mem, r_load_wb;

  logic w_m_ex_a, w_m_mem_a, w_m_wb_a;
  logic w_m_ex_b, w_m_mem_b, w_m_wb_b;
  logic w_ld_a, w_ld_b;
  logic w_stall, w_issue, w_entry_valid;

  always_comb begin
    w_m_ex_a  = rd_src_a_id_i & r_valid_ex  & (r_dst_ex  == src_a_identifier_id_i) &
                (src_a_identifier_id_i != '0);
    w_m_mem_a = rd_src_a_id_i & r_valid_mem & (r_dst_mem == src_a_identifier_id_i) &
                (src_a_identifier_id_i != '0);
    w_m_wb_a  = rd_src_a_id_i & r_valid_wb  & (r_dst_wb  == src_a_identifier_id_i) &
                (src_a_identifier_id_i != '0);
    w_m_ex_b  = rd_src_b_id_i & r_valid_ex  & (r_dst_ex  == src_b_identifier_id_i) &
                (src_b_identifier_id_i != '0);
    w_m_mem_b = rd_src_b_id_i & r_valid_mem & (r_dst_mem == src_b_identifier_id_i) &
                (src_b_identifier_id_i != '0);
    w_m_wb_b  = rd_src_b_id_i & r_valid_wb  & (r_dst_wb  == src_b_identifier_id_i) &
                (src_b_identifier_id_i != '0);

    // A load result only becomes forwardable once it reaches WB.
    w_ld_a = (w_m_ex_a & r_load_ex) | (~w_m_ex_a & w_m_mem_a & r_load_mem);
    w_ld_b = (w_m_ex_b & r_load_ex) | (~w_m_ex_b & w_m_mem_b & r_load_mem);

    w_stall       = valid_id_i & ~flush_i & (w_ld_a | w_ld_b);
    w_issue       = valid_id_i & ~w_stall & ~flush_i;
    w_entry_valid = w_issue & wr_rd_id_i & (dst_reg_identifier_id_i != '0);
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      r_valid_ex  <= 1'b0;
      r_valid_mem <= 1'b0;
      r_valid_wb  <= 1'b0;
      r_dst_ex    <= '0;
      r_dst_mem   <= '0;
      r_dst_wb    <= '0;
      r_load_ex   <= 1'b0;
      r_load_mem  <= 1'b0;
      r_load_wb   <= 1'b0;
    end else if (!hold_i) begin
      r_valid_wb  <= r_valid_mem;
      r_dst_wb    <= r_dst_mem;
      r_load_wb   <= r_load_mem;
      r_valid_mem <= r_valid_ex;
      r_dst_mem   <= r_dst_ex;
      r_load_mem  <= r_load_ex;
      r_valid_ex  <= w_entry_valid;
      r_dst_ex    <= w_entry_valid ? dst_reg_identifier_id_i : '0;
      r_load_ex   <= w_entry_valid & is_load_id_i;
    end
  end

  assign valid_ex_o               = r_valid_ex;
  assign valid_mem_o              = r_valid_mem;
  assign valid_wb_o               = r_valid_wb;
  assign dst_reg_identifier_ex_o  = r_dst_ex;
  assign dst_reg_identifier_mem_o = r_dst_mem;
  assign dst_reg_identifier_wb_o  = r_dst_wb;

  assign depEX_src_a_o  = w_m_ex_a;
  assign depEX_src_b_o  = w_m_ex_b;
  assign depMEM_src_a_o = w_m_mem_a & ~w_m_ex_a;
  assign depMEM_src_b_o = w_m_mem_b & ~w_m_ex_b;
  assign depWB_src_a_o  = w_m_wb_a & ~w_m_ex_a & ~w_m_mem_a;
  assign depWB_src_b_o  = w_m_wb_b & ~w_m_ex_b & ~w_m_mem_b;

  assign stall_id_o = w_stall;
  assign busy_o     = r_valid_ex | r_valid_mem | r_valid_wb;

endmodule

// File: tb/tb_segre_hazard_tracker.sv
// Directed bench for segre_hazard_tracker: forwarding distance, load-use stall, priority,
// x0 filtering, hold, asynchronous reset and flush-over-stall.
module tb_segre_hazard_tracker;

  logic       clk_i = 1'b0;
  logic       rsn_i;
  logic       valid_id_i, wr_rd_id_i, is_load_id_i;
  logic [4:0] dst_reg_identifier_id_i, src_a_identifier_id_i, src_b_identifier_id_i;
  logic       rd_src_a_id_i, rd_src_b_id_i, hold_i, flush_i;
  logic       valid_ex_o, valid_mem_o, valid_wb_o;
  logic [4:0] dst_reg_identifier_ex_o, dst_reg_identifier_mem_o, dst_reg_identifier_wb_o;
  logic       depEX_src_a_o, depEX_src_b_o, depMEM_src_a_o, depMEM_src_b_o;
  logic       depWB_src_a_o, depWB_src_b_o, stall_id_o, busy_o;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk_i = ~clk_i;

  segre_hazard_tracker #(.REG_SIZE(5)) dut (
    .clk_i                    (clk_i),
    .rsn_i                    (rsn_i),
    .valid_id_i               (valid_id_i),
    .wr_rd_id_i               (wr_rd_id_i),
    .is_load_id_i             (is_load_id_i),
    .dst_reg_identifier_id_i  (dst_reg_identifier_id_i),
    .src_a_identifier_id_i    (src_a_identifier_id_i),
    .src_b_identifier_id_i    (src_b_identifier_id_i),
    .rd_src_a_id_i            (rd_src_a_id_i),
    .rd_src_b_id_i            (rd_src_b_id_i),
    .hold_i                   (hold_i),
    .flush_i                  (flush_i),
    .valid_ex_o               (valid_ex_o),
    .valid_mem_o              (valid_mem_o),
    .valid_wb_o               (valid_wb_o),
    .dst_reg_identifier_ex_o  (dst_reg_identifier_ex_o),
    .dst_reg_identifier_mem_o (dst_reg_identifier_mem_o),
    .dst_reg_identifier_wb_o  (dst_reg_identifier_wb_o),
    .depEX_src_a_o            (depEX_src_a_o),
    .depEX_src_b_o            (depEX_src_b_o),
    .depMEM_src_a_o           (depMEM_src_a_o),
    .depMEM_src_b_o           (depMEM_src_b_o),
    .depWB_src_a_o            (depWB_src_a_o),
    .depWB_src_b_o            (depWB_src_b_o),
    .stall_id_o               (stall_id_o),
    .busy_o                   (busy_o)
  );

  // {exA, exB, memA, memB, wbA, wbB}
  wire [5:0]  deps = {depEX_src_a_o, depEX_src_b_o, depMEM_src_a_o, depMEM_src_b_o,
                      depWB_src_a_o, depWB_src_b_o};
  // {valid ex/mem/wb, dst ex, dst mem, dst wb}
  wire [17:0] pipe = {valid_ex_o, valid_mem_o, valid_wb_o, dst_reg_identifier_ex_o,
                      dst_reg_identifier_mem_o, dst_reg_identifier_wb_o};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_id(input logic v, input logic wr, input logic ld, input logic [4:0] dst,
                        input logic [4:0] sa, input logic ra, input logic [4:0] sb,
                        input logic rb);
    valid_id_i              = v;
    wr_rd_id_i              = wr;
    is_load_id_i            = ld;
    dst_reg_identifier_id_i = dst;
    src_a_identifier_id_i   = sa;
    rd_src_a_id_i           = ra;
    src_b_identifier_id_i   = sb;
    rd_src_b_id_i           = rb;
  endtask

  task automatic idle();
    set_id(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic drain();
    idle();
    repeat (4) tick();
  endtask

  initial begin
    rsn_i   = 1'b0;
    hold_i  = 1'b0;
    flush_i = 1'b0;
    idle();

    // Reset state
    #2;
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_pipe", pipe, 0);
    check_eq("rst_stall", stall_id_o, 0);
    #10 rsn_i = 1'b1;
    tick();
    check_eq("post_rst_pipe", pipe, 0);
    check_eq("post_rst_deps", deps, 0);

    // ADD x5, then readers at distance 1..4
    set_id(1'b1, 1'b1, 1'b0, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0);
    #1 check_eq("add_issue_stall", stall_id_o, 0);
    tick();
    set_id(1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 1'b1, 5'd0, 1'b0);
    #1;
    check_eq("fwd_ex_deps", deps, 6'b100000);
    check_eq("fwd_ex_stall", stall_id_o, 0);
    check_eq("fwd_ex_pipe", pipe, {3'b100, 5'd5, 5'd0, 5'd0});
    tick();
    check_eq("fwd_mem_deps", deps, 6'b001000);
    tick();
    check_eq("fwd_wb_deps", deps, 6'b000010);
    tick();
    check_eq("fwd_none_deps", deps, 0);
    check_eq("fwd_none_busy", busy_o, 0);
    drain();

    // LW x7, reader on src b directly behind
    set_id(1'b1, 1'b1, 1'b1, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    set_id(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd7, 1'b1);
    #1;
    check_eq("lu_c1_stall", stall_id_o, 1);
    check_eq("lu_c1_deps", deps, 6'b010000);
    tick();
    check_eq("lu_c2_stall", stall_id_o, 1);
    check_eq("lu_c2_deps", deps, 6'b000100);
    check_eq("lu_c2_bubble", valid_ex_o, 0);
    tick();
    check_eq("lu_c3_stall", stall_id_o, 0);
    check_eq("lu_c3_deps", deps, 6'b000001);
    check_eq("lu_c3_bubbles", pipe, {3'b001, 5'd0, 5'd0, 5'd7});
    drain();

    // ADD x3, SUB x3, reader of x3 on both sources: youngest wins
    set_id(1'b1, 1'b1, 1'b0, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    tick();
    set_id(1'b1, 1'b0, 1'b0, 5'd0, 5'd3, 1'b1, 5'd3, 1'b1);
    #1 check_eq("prio_deps", deps, 6'b110000);
    drain();

    // Write to x0, then reader of x0 which itself writes x9
    set_id(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    check_eq("x0_no_entry", busy_o, 0);
    set_id(1'b1, 1'b1, 1'b0, 5'd9, 5'd0, 1'b1, 5'd0, 1'b1);
    #1;
    check_eq("x0_src_deps", deps, 0);
    check_eq("x0_src_stall", stall_id_o, 0);
    tick();
    set_id(1'b1, 1'b0, 1'b0, 5'd0, 5'd9, 1'b0, 5'd0, 1'b0);
    #1;
    check_eq("noread_pipe", pipe, {3'b100, 5'd9, 5'd0, 5'd0});
    check_eq("noread_deps", deps, 0);
    check_eq("noread_stall", stall_id_o, 0);
    drain();

    // Hold with EX/MEM/WB populated; a valid ID instruction must not enter
    for (int i = 1; i <= 3; i++) begin
      set_id(1'b1, 1'b1, 1'b0, i[4:0], 5'd0, 1'b0, 5'd0, 1'b0);
      tick();
    end
    hold_i = 1'b1;
    set_id(1'b1, 1'b1, 1'b0, 5'd4, 5'd0, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("hold_frozen", pipe, {3'b111, 5'd3, 5'd2, 5'd1});
    end
    hold_i = 1'b0;
    idle();
    tick();
    check_eq("hold_release", pipe, {3'b011, 5'd0, 5'd3, 5'd2});
    drain();

    // Hold together with load-use: stall still reported, entries frozen
    set_id(1'b1, 1'b1, 1'b1, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    hold_i = 1'b1;
    set_id(1'b1, 1'b0, 1'b0, 5'd0, 5'd7, 1'b1, 5'd0, 1'b0);
    tick();
    check_eq("hold_stall", stall_id_o, 1);
    check_eq("hold_stall_pipe", pipe, {3'b100, 5'd7, 5'd0, 5'd0});
    hold_i = 1'b0;
    drain();

    // Asynchronous reset mid-cycle with all entries valid
    for (int i = 1; i <= 3; i++) begin
      set_id(1'b1, 1'b1, 1'b0, i[4:0], 5'd0, 1'b0, 5'd0, 1'b0);
      tick();
    end
    set_id(1'b1, 1'b0, 1'b0, 5'd0, 5'd3, 1'b1, 5'd0, 1'b0);
    #1 check_eq("pre_arst_deps", deps, 6'b100000);
    rsn_i = 1'b0;
    #1;
    check_eq("arst_busy", busy_o, 0);
    check_eq("arst_pipe", pipe, 0);
    check_eq("arst_deps", deps, 0);
    rsn_i = 1'b1;
    tick();
    check_eq("arst_after", busy_o, 0);
    drain();

    // Flush together with a load-use stall: flush wins, bubble enters EX
    set_id(1'b1, 1'b1, 1'b1, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    set_id(1'b1, 1'b1, 1'b0, 5'd8, 5'd7, 1'b1, 5'd0, 1'b0);
    flush_i = 1'b1;
    #1;
    check_eq("flush_stall", stall_id_o, 0);
    check_eq("flush_deps", deps, 6'b100000);
    tick();
    flush_i = 1'b0;
    idle();
    #1 check_eq("flush_bubble", pipe, {3'b010, 5'd0, 5'd7, 5'd0});

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
